// File: rtl/wb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_pkg;

    localparam int WB_DW = 8;
    localparam int WB_AW = 16;

    localparam logic CPU = 1'b0;
    localparam logic DBG = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Bus bundle between the CPU/debug masters, the arbiter and the slave.
interface wb_bus_arbiter_if #(
    parameter int AW = wb_pkg::WB_AW,
    parameter int DW = wb_pkg::WB_DW
);
    logic          m0_stb_i;
    logic          m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic          m0_ack_o;
    logic          m0_err_o;
    logic [DW-1:0] m0_dat_o;

    logic          m1_stb_i;
    logic          m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic          m1_ack_o;
    logic          m1_err_o;
    logic [DW-1:0] m1_dat_o;
    logic          m1_lock_i;

    logic          s_stb_o;
    logic          s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic          s_ack_i;
    logic [DW-1:0] s_dat_i;

    logic          busy_o;
    logic          grant_o;

    // Arbiter side: serves the masters, drives the slave.
    modport slave (
        input  m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
        output m0_ack_o, m0_err_o, m0_dat_o,
        input  m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_lock_i,
        output m1_ack_o, m1_err_o, m1_dat_o,
        output s_stb_o, s_we_o, s_adr_o, s_dat_o,
        input  s_ack_i, s_dat_i,
        output busy_o, grant_o
    );

    modport master (
        output m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i,
        input  m0_ack_o, m0_err_o, m0_dat_o,
        output m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_lock_i,
        input  m1_ack_o, m1_err_o, m1_dat_o,
        input  s_stb_o, s_we_o, s_adr_o, s_dat_o,
        output s_ack_i, s_dat_i,
        input  busy_o, grant_o
    );

endinterface

// File: rtl/wb_rr_pick.sv
// Two-way round-robin pick; the debug port may hold the bus with lock.
module wb_rr_pick
    import wb_pkg::*;
(
    input  logic i_stb0,
    input  logic i_stb1,
    input  logic i_last,
    input  logic i_lock,
    output logic o_req,
    output logic o_grant
);

    always_comb begin
        o_req   = i_stb0 | i_stb1;
        o_grant = CPU;
        unique case (1'b1)
            (i_stb0 && i_stb1):
                o_grant = (i_last && i_lock) ? DBG : ~i_last;
            (i_stb1 && !i_stb0):
                o_grant = DBG;
            default:
                o_grant = CPU;
        endcase
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter: one single-cycle slave strobe per grant,
// with a bounded wait for the slave ack.
module wb_bus_arbiter
    import wb_pkg::*;
#(
    parameter int WB_DATA_WIDTH = WB_DW,
    parameter int WB_ADDR_WIDTH = WB_AW,
    parameter int TIMEOUT       = 15
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    wb_bus_arbiter_if.slave bus
);

    localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);

    state_e                     r_state;
    state_e                     w_next;
    logic                       r_last;
    logic                       r_grant;
    logic                       r_err;
    logic [7:0]                 r_cnt;
    logic                       r_we;
    logic [WB_ADDR_WIDTH-1:0]   r_adr;
    logic [WB_DATA_WIDTH-1:0]   r_dat;
    logic [WB_DATA_WIDTH-1:0]   r_m0_dat;
    logic [WB_DATA_WIDTH-1:0]   r_m1_dat;

    logic                       w_req;
    logic                       w_pick;
    logic                       w_ack_cap;
    logic                       w_tmo;
    logic [WB_DATA_WIDTH-1:0]   w_cap_dat;

    wb_rr_pick u_pick (
        .i_stb0  (bus.m0_stb_i),
        .i_stb1  (bus.m1_stb_i),
        .i_last  (r_last),
        .i_lock  (bus.m1_lock_i),
        .o_req   (w_req),
        .o_grant (w_pick)
    );

    always_comb begin
        w_next    = r_state;
        w_ack_cap = 1'b0;
        w_tmo     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_req) w_next = ISSUE;
            end
            ISSUE: begin
                w_next = WAIT;
                if (bus.s_ack_i) begin
                    w_ack_cap = 1'b1;
                    w_next    = DONE;
                end
            end
            WAIT: begin
                // A late ack on the expiry cycle still counts as success.
                if (bus.s_ack_i) begin
                    w_ack_cap = 1'b1;
                    w_next    = DONE;
                end else if (r_cnt == LP_TMO_LAST) begin
                    w_tmo  = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_cap_dat = w_tmo ? '1 : bus.s_dat_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_last   <= DBG;
            r_grant  <= CPU;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_m0_dat <= '0;
            r_m1_dat <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_req) begin
                r_grant <= w_pick;
                r_we    <= w_pick ? bus.m1_we_i  : bus.m0_we_i;
                r_adr   <= w_pick ? bus.m1_adr_i : bus.m0_adr_i;
                r_dat   <= w_pick ? bus.m1_dat_i : bus.m0_dat_i;
            end
            if (w_ack_cap || w_tmo) begin
                r_err <= w_tmo;
                if (r_grant) r_m1_dat <= w_cap_dat;
                else         r_m0_dat <= w_cap_dat;
            end
            r_cnt <= (r_state == WAIT) ? r_cnt + 8'd1 : '0;
            if (r_state == DONE) r_last <= r_grant;
        end
    end

    assign bus.s_stb_o  = (r_state == ISSUE);
    assign bus.s_we_o   = r_we;
    assign bus.s_adr_o  = r_adr;
    assign bus.s_dat_o  = r_dat;

    assign bus.m0_ack_o = (r_state == DONE) && (r_grant == CPU);
    assign bus.m1_ack_o = (r_state == DONE) && (r_grant == DBG);
    assign bus.m0_err_o = bus.m0_ack_o && r_err;
    assign bus.m1_err_o = bus.m1_ack_o && r_err;
    assign bus.m0_dat_o = r_m0_dat;
    assign bus.m1_dat_o = r_m1_dat;

    assign bus.busy_o   = (r_state != IDLE);
    assign bus.grant_o  = r_grant;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter with a scoreboard of expected
// completions and a configurable slave model.
module tb_wb_bus_arbiter;
    import wb_pkg::*;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 15;

    typedef struct {
        logic          m;
        logic          err;
        logic [DW-1:0] dat;
    } exp_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    int checks   = 0;
    int errors   = 0;
    int acks     = 0;
    int stb_cnt  = 0;
    int wr_cnt   = 0;
    int stb_long = 0;

    // slave model: 0 = ack one cycle after stb, 1 = same cycle,
    // 2 = never ack, 3 = ack driven by man_ack
    int            smode    = 0;
    logic          man_ack  = 1'b0;
    logic          stb_prev = 1'b0;
    logic          pend     = 1'b0;
    logic [DW-1:0] pend_dat = '0;

    exp_t sbq[$];
    exp_t mon_e;

    always #5 clk_i = ~clk_i;

    wb_bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    wb_bus_arbiter #(
        .WB_DATA_WIDTH (DW),
        .WB_ADDR_WIDTH (AW),
        .TIMEOUT       (TO)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (bus.s_stb_o) begin
            stb_cnt++;
            if (bus.s_we_o) wr_cnt++;
            if (stb_prev) stb_long++;
        end
        stb_prev = bus.s_stb_o;
        bus.s_ack_i = 1'b0;
        case (smode)
            0: begin
                bus.s_ack_i = pend;
                bus.s_dat_i = pend_dat;
                pend        = bus.s_stb_o;
                pend_dat    = bus.s_adr_o[7:0] ^ 8'hA5;
            end
            1: begin
                pend        = 1'b0;
                bus.s_ack_i = bus.s_stb_o;
                bus.s_dat_i = bus.s_adr_o[7:0] ^ 8'hA5;
            end
            3: begin
                pend        = 1'b0;
                bus.s_ack_i = man_ack;
                bus.s_dat_i = 8'h77;
            end
            default: begin
                pend = 1'b0;
            end
        endcase
    end

    always @(posedge clk_i) begin
        #1;
        if (bus.m0_ack_o || bus.m1_ack_o) begin
            acks++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_ack observed m0=%0b m1=%0b expected none",
                       bus.m0_ack_o, bus.m1_ack_o);
            end else begin
                mon_e = sbq.pop_front();
                chk("ack_sel", {30'd0, bus.m1_ack_o, bus.m0_ack_o},
                    mon_e.m ? 32'd2 : 32'd1);
                chk("err", {30'd0, bus.m1_err_o, bus.m0_err_o},
                    mon_e.m ? {30'd0, mon_e.err, 1'b0} : {31'd0, mon_e.err});
                chk("dat", mon_e.m ? bus.m1_dat_o : bus.m0_dat_o, mon_e.dat);
                chk("grant", bus.grant_o, mon_e.m);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic push(logic m, logic err, logic [DW-1:0] dat);
        exp_t e;
        e.m   = m;
        e.err = err;
        e.dat = dat;
        sbq.push_back(e);
    endtask

    task automatic drive(logic m, logic stb, logic we,
                         logic [AW-1:0] adr, logic [DW-1:0] dat);
        if (m) begin
            bus.m1_stb_i = stb;
            bus.m1_we_i  = we;
            bus.m1_adr_i = adr;
            bus.m1_dat_i = dat;
        end else begin
            bus.m0_stb_i = stb;
            bus.m0_we_i  = we;
            bus.m0_adr_i = adr;
            bus.m0_dat_i = dat;
        end
    endtask

    task automatic xfer(logic m, logic we, logic [AW-1:0] adr,
                        logic [DW-1:0] dat, output int lat);
        lat = 0;
        drive(m, 1'b1, we, adr, dat);
        for (int i = 1; i <= 60; i++) begin
            tick();
            if ((m ? bus.m1_ack_o : bus.m0_ack_o) === 1'b1) begin
                lat = i;
                break;
            end
        end
        drive(m, 1'b0, 1'b0, '0, '0);
        if (lat == 0) begin
            checks++;
            errors++;
            $error("FAIL xfer_bound observed=no_ack expected=ack m=%0b", m);
        end
    endtask

    task automatic wait_acks(int target);
        for (int i = 0; i < 400; i++) begin
            if (acks >= target) return;
            tick();
        end
        checks++;
        errors++;
        $error("FAIL ack_bound observed=%0d expected=%0d", acks, target);
    endtask

    initial begin
        int lat;
        int base;
        int s0;
        int w0;

        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        bus.m1_lock_i = 1'b0;
        bus.s_ack_i   = 1'b0;
        bus.s_dat_i   = '0;

        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_grant", bus.grant_o, 0);
        chk("rst_sbus", {bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o}, 0);
        chk("rst_ack", {bus.m1_ack_o, bus.m0_ack_o, bus.m1_err_o, bus.m0_err_o}, 0);
        chk("rst_dat", {bus.m1_dat_o, bus.m0_dat_o}, 0);
        rst_ni = 1'b1;
        tick();

        // both masters requesting continuously: strict alternation from m0
        base = acks;
        w0   = wr_cnt;
        s0   = stb_cnt;
        for (int i = 0; i < 8; i++)
            push(1'(i % 2), 1'b0, (i % 2) ? 8'h24 : 8'hB5);
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00);
        drive(1'b1, 1'b1, 1'b1, 16'h0081, 8'h33);
        wait_acks(base + 8);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (4) tick();
        chk("rr_sb_empty", sbq.size(), 0);
        chk("rr_writes", wr_cnt - w0, 4);
        chk("rr_strobes", stb_cnt - s0, 8);

        // lock keeps the debug port on the bus until released
        base = acks;
        bus.m1_lock_i = 1'b1;
        for (int i = 0; i < 4; i++)
            push(1'b1, 1'b0, 8'h24);
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00);
        drive(1'b1, 1'b1, 1'b1, 16'h0081, 8'h33);
        wait_acks(base + 4);
        bus.m1_lock_i = 1'b0;
        push(1'b0, 1'b0, 8'hB5);
        wait_acks(base + 5);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (4) tick();
        chk("lock_sb_empty", sbq.size(), 0);

        // CPU write through a registered-ack slave
        s0 = stb_cnt;
        w0 = wr_cnt;
        push(1'b0, 1'b0, 8'h8F);
        xfer(1'b0, 1'b1, 16'h002A, 8'h00, lat);
        chk("tia_latency", lat, 3);
        tick();
        chk("tia_strobes", stb_cnt - s0, 1);
        chk("tia_writes", wr_cnt - w0, 1);
        chk("tia_sadr", bus.s_adr_o, 16'h002A);
        chk("tia_sdat", bus.s_dat_o, 8'h00);

        // silent slave: timeout completion
        smode = 2;
        push(1'b1, 1'b1, 8'hFF);
        xfer(1'b1, 1'b0, 16'h0055, 8'h00, lat);
        chk("tmo_latency", lat, TO + 2);
        tick();
        chk("tmo_busy", bus.busy_o, 0);
        chk("tmo_m0_dat_kept", bus.m0_dat_o, 8'h8F);

        // zero-latency slave
        smode = 1;
        s0 = stb_cnt;
        push(1'b0, 1'b0, 8'h5C);
        xfer(1'b0, 1'b0, 16'h00F9, 8'h00, lat);
        chk("zl_latency", lat, 2);
        tick();
        chk("zl_strobes", stb_cnt - s0, 1);
        chk("zl_m0_dat", bus.m0_dat_o, 8'h5C);

        // spurious slave ack while idle
        smode   = 3;
        man_ack = 1'b1;
        base    = acks;
        repeat (5) tick();
        chk("spur_acks", acks - base, 0);
        chk("spur_dat", {bus.m1_dat_o, bus.m0_dat_o}, 16'hFF5C);
        chk("spur_busy", bus.busy_o, 0);
        man_ack = 1'b0;
        smode   = 2;
        tick();

        // reset in the middle of a wait
        base = acks;
        drive(1'b1, 1'b1, 1'b0, 16'h1234, 8'h00);
        repeat (4) tick();
        chk("prerst_busy", bus.busy_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("arst_busy", bus.busy_o, 0);
        chk("arst_grant", bus.grant_o, 0);
        chk("arst_sbus", {bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.s_dat_o}, 0);
        chk("arst_ack", {bus.m1_ack_o, bus.m0_ack_o, bus.m1_err_o, bus.m0_err_o}, 0);
        chk("arst_dat", {bus.m1_dat_o, bus.m0_dat_o}, 0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (2) tick();
        rst_ni = 1'b1;
        smode  = 0;
        tick();
        chk("arst_no_ack", acks - base, 0);

        // first tie after reset goes to the CPU
        base = acks;
        push(1'b0, 1'b0, 8'hB5);
        push(1'b1, 1'b0, 8'h24);
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00);
        drive(1'b1, 1'b1, 1'b1, 16'h0081, 8'h33);
        wait_acks(base + 2);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (4) tick();
        chk("tie_sb_empty", sbq.size(), 0);
        chk("stb_single_cycle", stb_long, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-master, one-slave Wishbone arbiter in front of the TIA and RAM address decoder.
- Master 0 is the 6502 CPU core; master 1 is the debug/loader port, which pokes TIA registers and RAM from the host.
- It serialises accesses and converts each granted request into exactly one single-cycle slave strobe. This matters because the TIA performs side effects on every strobed cycle (WSYNC, HMOVE, CXCLR, RESxx).
- It also bounds every access with an ack timeout.

Parameters:
- WB_DATA_WIDTH, 8: data bus width.
- WB_ADDR_WIDTH, 16: address width passed through unchanged to the slave.
- TIMEOUT, 15: cycles spent in WAIT without s_ack_i before an error ack is returned (1..255).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous, active-low reset.
- m0_stb_i  in  1  CPU request.
- m0_we_i  in  1  CPU write enable.
- m0_adr_i  in  WB_ADDR_WIDTH  CPU address.
- m0_dat_i  in  WB_DATA_WIDTH  CPU write data.
- m0_ack_o  out  1  CPU ack, one-cycle pulse.
- m0_err_o  out  1  CPU timeout flag, valid with m0_ack_o.
- m0_dat_o  out  WB_DATA_WIDTH  CPU read data.
- m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_ack_o, m1_err_o, m1_dat_o: as m0, for the debug port.
- m1_lock_i  in  1  debug port holds the bus across consecutive accesses.
- s_stb_o  out  1  slave strobe.
- s_we_o  out  1  slave write enable.
- s_adr_o  out  WB_ADDR_WIDTH  slave address.
- s_dat_o  out  WB_DATA_WIDTH  slave write data.
- s_ack_i  in  1  slave ack.
- s_dat_i  in  WB_DATA_WIDTH  slave read data.
- busy_o  out  1  high whenever the state is not IDLE.
- grant_o  out  1  index of the current or most recent grant.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All ack, err, stb and we outputs are 0; all data and address outputs are 0.
  - last_grant=1, so the CPU wins the first tie.
  - timeout counter=0; grant_o=0.
- States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
- IDLE: sample the stb inputs.
  - Neither set: stay in IDLE.
  - Exactly one set: grant that master.
  - Both set: grant !last_grant (round-robin). Exception: if last_grant=1 and m1_lock_i=1, grant m1 again.
  - On a grant: latch we/adr/dat of the granted master into the s_* registers, set grant_o, and go to ISSUE.
- ISSUE (exactly 1 cycle): s_stb_o=1.
  - If s_ack_i is high this cycle, capture s_dat_i and go to DONE.
  - Otherwise go to WAIT.
- WAIT: s_stb_o=0; the counter increments each cycle.
  - s_ack_i=1: capture s_dat_i into the granted master's dat_o register, err=0, go to DONE.
  - Counter reaches TIMEOUT-1 with no ack: dat_o=all ones, err=1, go to DONE.
  - s_ack_i on the expiry cycle wins; that is a normal completion.
- DONE (exactly 1 cycle):
  - The granted master's ack_o=1; err_o=1 if timed out.
  - The other master's ack/err stay 0.
  - last_grant is updated to the served master; the counter is cleared; go to IDLE.
- dat_o of each master holds its last captured value until that master's next completion.
- Latency with the TIA (ack registered one cycle after stb): request sampled at cycle N, s_stb_o at N+1, s_ack_i at N+2, mX_ack_o at N+3. The next grant is evaluated at N+4.
- The slave never sees stb for more than one cycle per transaction; s_stb_o is never high outside ISSUE.
- s_ack_i in IDLE or DONE is ignored. It must not produce a master ack or change any data output.
- A master that drops stb while granted (protocol violation) still completes. Its ack is issued normally and a master whose stb is low simply ignores it.
- A master that holds stb after its ack is treated as a new request in IDLE.
- Reset asserted mid-transaction aborts immediately to the reset values. No ack is issued for the aborted access.
- Master inputs are sampled only in IDLE; changes after the grant do not affect the in-flight access.

Decomposition:
- Shared package wb_pkg:
  - state encoding localparams (IDLE=0, ISSUE=1, WAIT=2, DONE=3);
  - master index constants CPU=0, DBG=1;
  - default bus widths.
- One natural sub-module, wb_rr_pick: combinational two-way round-robin/lock selection from (stb0, stb1, last_grant, lock). The FSM, timeout counter and datapath stay in the top module.

Test Plan:
- CPU only, TIA-model slave (ack 1 cycle after stb): m0 write adr=0x2A dat=0x00 -> s_stb_o high exactly 1 cycle; m0_ack_o at N+3; slave sees one write; m0_err_o=0.
- Both masters request every cycle, 8 transactions -> grants alternate m0,m1,m0,m1,...; the first grant after reset goes to m0; no master ever waits two consecutive transactions.
- m1_lock_i=1 with both requesting -> after the first m1 grant, m1 is granted 4 times in a row; lock dropped -> the next grant goes to m0.
- Slave never acks, m1 read -> m1_ack_o and m1_err_o asserted exactly TIMEOUT+2 cycles after the request is sampled; m1_dat_o=0xFF; busy_o low on the following cycle.
- Zero-latency slave (ack in the same cycle as stb) returning 0x5C on a CPU read -> completion in DONE at N+2; m0_dat_o=0x5C; s_stb_o still a single-cycle pulse.
- Spurious s_ack_i in IDLE, plus rst_ni pulsed low while in WAIT -> no master ack; all outputs return to reset values asynchronously; the first post-reset tie is granted to m0.
